cp_metric_peak_detect: RTL and testbench
========================================

// Module: cp_metric_peak_detect
// PURPOSE
//  Downstream consumer of the per-sample CP-correlation stream (corr = r(k)*conj(r(k-N)), energy = rho/2*(|r(k)|^2+|r(k-N)|^2)).
//  - Forms CP_LEN-sample sliding-window sums gamma (complex) and phi.
//  - Evaluates the ML timing metric |gamma| - phi for every sample.
//  - Reports, once per OFDM symbol period, the index of the metric peak and gamma at that peak (for CFO estimation).
// PARAMETERS
//  WL_IN    20                       width of signed corr_real/corr_imag/energy inputs
//  CP_LEN   16                       window length in samples (power of 2, >=2)
//  FFT_SIZE 256                      useful symbol length; SYM_LEN = FFT_SIZE+CP_LEN (localparam, 272)
//  WL_ACC   WL_IN+$clog2(CP_LEN)     window-sum width (24 at defaults)
// PORTS
//  clk             in   1                     clock; all logic on posedge
//  rst_n           in   1                     asynchronous, active-low reset
//  clear           in   1                     synchronous flush: empties window, returns to FILL
//  in_valid        in   1                     input sample qualifier
//  corr_real_in    in   WL_IN s               correlation, real part
//  corr_imag_in    in   WL_IN s               correlation, imaginary part
//  energy_in       in   WL_IN s               scaled energy term
//  out_valid       out  1                     one-cycle report pulse
//  theta_out       out  $clog2(SYM_LEN)       peak sample index within the symbol period (0..SYM_LEN-1)
//  gamma_real_out  out  WL_ACC s              window sum at peak, real part
//  gamma_imag_out  out  WL_ACC s              window sum at peak, imaginary part
//  metric_out      out  WL_ACC+2 s            peak metric value
// BEHAVIOUR
//  Reset: every output 0; FSM = FILL; delay lines, sums, counters and pipeline valid tags cleared.
//  Reset is accepted in any cycle, mid-symbol included; the aborted symbol produces no report.
//  Window:
//   - Per component, a CP_LEN-deep circular delay line.
//   - On in_valid: sum <= sum + x_new - x_old, where x_old = 0 until CP_LEN samples have been written.
//   - Write pointer wraps CP_LEN-1 -> 0.
//   - Sums are exact; no saturation is needed at WL_ACC.
//  FSM:
//   - FILL: accept samples; no metric evaluation. After the CP_LEN-th accepted sample -> SEARCH, sample index = 0.
//   - SEARCH: each accepted sample is tagged with the current index (0..SYM_LEN-1, wraps to 0).
//   - The window is never re-filled except after clear or reset.
//  Pipeline: 3 stages, advancing every cycle with a valid tag. Bubbles on in_valid propagate as invalid tags.
//   - A: window update (registered sums + index tag).
//   - B: magnitude and metric (registered).
//     - mag = max(|gr|,|gi|) + (min>>>2) + (min>>>3), alpha-max-beta-min with beta = 3/8.
//     - |x| of the most-negative value saturates to +max.
//     - metric = mag - phi, width WL_ACC+2.
//   - C: compare against the running max.
//     - The running max is initialised to the most-negative value at index 0 of each period.
//     - Update only on strictly greater, so ties keep the earliest index.
//  Report:
//   - When the stage-C valid tag carries index SYM_LEN-1: outputs latched from the best candidate (including this sample), out_valid = 1 for exactly one cycle.
//   - Max is re-armed for the next period.
//   - Latency: out_valid rises 3 cycles after the clk edge accepting index SYM_LEN-1 (no bubbles behind it required).
//   - Outputs hold their value between reports.
//  clear:
//   - Clears delay lines, sums, index, running max and pipeline tags; FSM -> FILL.
//   - clear with in_valid in the same cycle: clear wins, sample dropped.
//   - clear coincident with a pending report: report suppressed.
// STRUCTURE
//  Package ofdm_sync_pkg:
//   - WL_IN/WL_ACC/CP_LEN/FFT_SIZE defaults and the SYM_LEN localparam.
//   - typedef enum {FILL, SEARCH} sync_state_t.
//   - function abs_sat().
//  Sub-module cp_window_sum #(W, DEPTH): delay line + running sum with clear, instantiated 3x (real, imag, energy).
//  Top: FSM, index counter, magnitude/metric stage, peak tracker, output registers.
// TESTING
//  1 Assert rst_n=0 mid-stream, release -> all outputs 0, out_valid 0, first 16 samples produce no evaluation.
//  2 FILL with corr_real=1, others 0 -> sum_real reaches 16 at the 16th sample, stays 16 while input is held.
//  3 After fill, zeros except corr_real=100 for indices 50..65 -> theta_out=65, gamma_real_out=1600, gamma_imag_out=0, metric_out=1600; pulse 3 cycles after index 271.
//  4 Two identical plateaus ending at 65 and 200 -> theta_out=65 (earliest tie).
//  5 Repeat test 3 with in_valid toggled every other cycle -> identical outputs, pulse 3 cycles after the last accepted sample.
//  6 clear together with in_valid at index 120 -> sample dropped, no report for that period, refill of 16 samples before index 0 restarts.

Source files
------------

// File: rtl/ofdm_sync_pkg.sv
// Shared types and defaults for the CP-based OFDM timing sync path.
// Holds the FSM state type and the saturating magnitude helper.
package ofdm_sync_pkg;

  localparam int SYNC_WL_IN    = 20;
  localparam int SYNC_CP_LEN   = 16;
  localparam int SYNC_FFT_SIZE = 256;
  localparam int SYNC_WL_ACC   = SYNC_WL_IN + $clog2(SYNC_CP_LEN);
  localparam int SYNC_SYM_LEN  = SYNC_FFT_SIZE + SYNC_CP_LEN;

  typedef enum logic {
    FILL,
    SEARCH
  } sync_state_t;

  // |x| of a w-bit value; the most-negative code maps to +max
  function automatic logic signed [63:0] abs_sat(
    input logic signed [63:0] x,
    input int                 w
  );
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (w - 1);
    if (x <= -lim)   abs_sat = lim - 64'sd1;
    else if (x < 0)  abs_sat = -x;
    else             abs_sat = x;
  endfunction

endpackage

// File: rtl/cp_window_sum.sv
// Sliding-window sum over the last DEPTH accepted samples.
// The zeroed delay line makes the first DEPTH removals contribute 0.
module cp_window_sum #(
  parameter int W     = 20,
  parameter int DEPTH = 16,
  parameter int SW    = W + $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic signed [W-1:0]  x,
  output logic signed [SW-1:0] sum
);

  localparam int PW = $clog2(DEPTH);

  logic signed [W-1:0] dl [DEPTH];
  logic [PW-1:0]       ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      sum <= '0;
      for (int i = 0; i < DEPTH; i++) dl[i] <= '0;
    end else if (clear) begin
      ptr <= '0;
      sum <= '0;
      for (int i = 0; i < DEPTH; i++) dl[i] <= '0;
    end else if (en) begin
      dl[ptr] <= x;
      ptr     <= ptr + 1'b1;
      sum     <= sum + SW'(x) - SW'(dl[ptr]);
    end
  end

endmodule

// File: rtl/cp_metric_peak_detect.sv
// ML timing metric |gamma|-phi over a CP-length window; reports the
// per-symbol-period peak index and gamma at that peak.
module cp_metric_peak_detect
  import ofdm_sync_pkg::*;
#(
  parameter int WL_IN    = SYNC_WL_IN,
  parameter int CP_LEN   = SYNC_CP_LEN,
  parameter int FFT_SIZE = SYNC_FFT_SIZE,
  parameter int WL_ACC   = WL_IN + $clog2(CP_LEN)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 in_valid,
  input  logic signed [WL_IN-1:0]              corr_real_in,
  input  logic signed [WL_IN-1:0]              corr_imag_in,
  input  logic signed [WL_IN-1:0]              energy_in,
  output logic                                 out_valid,
  output logic [$clog2(FFT_SIZE+CP_LEN)-1:0]   theta_out,
  output logic signed [WL_ACC-1:0]             gamma_real_out,
  output logic signed [WL_ACC-1:0]             gamma_imag_out,
  output logic signed [WL_ACC+1:0]             metric_out
);

  localparam int SYM_LEN = FFT_SIZE + CP_LEN;
  localparam int IDX_W   = $clog2(SYM_LEN);
  localparam int MW      = WL_ACC + 2;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SYM_LEN - 1);
  localparam logic [IDX_W-1:0] FILL_LAST = IDX_W'(CP_LEN - 1);
  localparam logic signed [MW-1:0] MET_MIN = {1'b1, {(MW-1){1'b0}}};

  sync_state_t      state, state_n;
  logic [IDX_W-1:0] cnt, cnt_n;
  logic             acc, a_vld_n;

  assign acc = in_valid & ~clear;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_vld_n = 1'b0;
    if (clear) begin
      state_n = FILL;
      cnt_n   = '0;
    end else if (in_valid) begin
      case (state)
        FILL: begin
          if (cnt == FILL_LAST) begin
            state_n = SEARCH;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        SEARCH: begin
          a_vld_n = 1'b1;
          cnt_n   = (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end
        default: state_n = FILL;
      endcase
    end
  end

  logic             a_vld;
  logic [IDX_W-1:0] a_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      cnt   <= '0;
      a_vld <= 1'b0;
      a_idx <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      a_vld <= a_vld_n;
      if (acc) a_idx <= cnt;
    end
  end

  logic signed [WL_ACC-1:0] sum_re, sum_im, sum_en;

  cp_window_sum #(.W(WL_IN), .DEPTH(CP_LEN), .SW(WL_ACC)) u_win_re (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(acc),
    .x(corr_real_in), .sum(sum_re)
  );

  cp_window_sum #(.W(WL_IN), .DEPTH(CP_LEN), .SW(WL_ACC)) u_win_im (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(acc),
    .x(corr_imag_in), .sum(sum_im)
  );

  cp_window_sum #(.W(WL_IN), .DEPTH(CP_LEN), .SW(WL_ACC)) u_win_en (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(acc),
    .x(energy_in), .sum(sum_en)
  );

  // alpha-max-beta-min magnitude, beta = 3/8
  logic signed [MW-1:0] ar, ai, mx, mn, mag, met_a;

  always_comb begin
    ar    = MW'(abs_sat(64'(sum_re), WL_ACC));
    ai    = MW'(abs_sat(64'(sum_im), WL_ACC));
    mx    = (ar > ai) ? ar : ai;
    mn    = (ar > ai) ? ai : ar;
    mag   = mx + (mn >>> 2) + (mn >>> 3);
    met_a = mag - MW'(sum_en);
  end

  logic                     b_vld, c_rep;
  logic [IDX_W-1:0]         b_idx, best_idx;
  logic signed [WL_ACC-1:0] b_gr, b_gi, best_gr, best_gi;
  logic signed [MW-1:0]     b_met, best_met;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_vld          <= 1'b0;
      b_idx          <= '0;
      b_gr           <= '0;
      b_gi           <= '0;
      b_met          <= '0;
      c_rep          <= 1'b0;
      best_idx       <= '0;
      best_gr        <= '0;
      best_gi        <= '0;
      best_met       <= MET_MIN;
      out_valid      <= 1'b0;
      theta_out      <= '0;
      gamma_real_out <= '0;
      gamma_imag_out <= '0;
      metric_out     <= '0;
    end else if (clear) begin
      b_vld     <= 1'b0;
      c_rep     <= 1'b0;
      best_met  <= MET_MIN;
      out_valid <= 1'b0;
    end else begin
      b_vld <= a_vld;
      if (a_vld) begin
        b_idx <= a_idx;
        b_gr  <= sum_re;
        b_gi  <= sum_im;
        b_met <= met_a;
      end
      c_rep <= b_vld && (b_idx == LAST_IDX);
      // index 0 re-arms the period; strict > keeps the earliest tie
      if (b_vld && (b_idx == '0 || b_met > best_met)) begin
        best_idx <= b_idx;
        best_gr  <= b_gr;
        best_gi  <= b_gi;
        best_met <= b_met;
      end
      out_valid <= c_rep;
      if (c_rep) begin
        theta_out      <= best_idx;
        gamma_real_out <= best_gr;
        gamma_imag_out <= best_gi;
        metric_out     <= best_met;
      end
    end
  end

endmodule

// File: tb/tb_cp_metric_peak_detect.sv
// Bench for cp_metric_peak_detect: directed vector table, hand
// sequences for clear/reset, and random traffic against a window model.
module tb_cp_metric_peak_detect;

  localparam int CP  = 16;
  localparam int SYM = 272;
  localparam int WA  = 24;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [19:0] corr_real_in = '0;
  logic signed [19:0] corr_imag_in = '0;
  logic signed [19:0] energy_in = '0;
  logic               out_valid;
  logic [8:0]         theta_out;
  logic signed [23:0] gamma_real_out;
  logic signed [23:0] gamma_imag_out;
  logic signed [25:0] metric_out;

  cp_metric_peak_detect dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .corr_real_in(corr_real_in), .corr_imag_in(corr_imag_in),
    .energy_in(energy_in), .out_valid(out_valid), .theta_out(theta_out),
    .gamma_real_out(gamma_real_out), .gamma_imag_out(gamma_imag_out),
    .metric_out(metric_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  // reference model: history of accepted samples + per-period argmax
  longint qr[$], qi[$], qe[$];
  bit     m_search;
  int     m_cnt, m_idx, bst_idx;
  longint bst_met, bst_gr, bst_gi;

  typedef struct {
    int     due;
    int     theta;
    longint gr, gi, met;
  } exp_t;
  exp_t expq[$];

  function automatic longint absx(longint x);
    longint lim;
    lim = longint'(1) <<< (WA - 1);
    if (x == -lim) return lim - 1;
    return (x < 0) ? -x : x;
  endfunction

  function automatic longint magx(longint gr, longint gi);
    longint a, b, mx, mn;
    a = absx(gr);
    b = absx(gi);
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return mx + mn / 4 + mn / 8;
  endfunction

  task automatic model_reset();
    qr.delete(); qi.delete(); qe.delete();
    m_search = 0; m_cnt = 0; m_idx = 0;
    expq.delete();
  endtask

  task automatic model_clear(input int n);
    exp_t keep[$];
    qr.delete(); qi.delete(); qe.delete();
    m_search = 0; m_cnt = 0; m_idx = 0;
    foreach (expq[i]) if (expq[i].due < n) keep.push_back(expq[i]);
    expq = keep;
  endtask

  task automatic model_accept(input int re, im, e, input int n);
    longint gr, gi, met;
    qr.push_back(re); qi.push_back(im); qe.push_back(e);
    if (qr.size() > CP) begin
      void'(qr.pop_front()); void'(qi.pop_front()); void'(qe.pop_front());
    end
    if (!m_search) begin
      m_cnt++;
      if (m_cnt == CP) begin m_search = 1; m_idx = 0; end
    end else begin
      gr = qr.sum(); gi = qi.sum();
      met = magx(gr, gi) - qe.sum();
      if (m_idx == 0 || met > bst_met) begin
        bst_met = met; bst_gr = gr; bst_gi = gi; bst_idx = m_idx;
      end
      if (m_idx == SYM - 1)
        expq.push_back('{n + 3, bst_idx, bst_gr, bst_gi, bst_met});
      m_idx = (m_idx + 1) % SYM;
    end
  endtask

  // report monitor against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        pulse_cnt++;
        checks++;
        if (expq.size() == 0 || expq[0].due != cyc) begin
          failures++;
          $display("FAIL model_pulse cyc=%0d unexpected out_valid theta=%0d",
                   cyc, theta_out);
        end else begin
          if (theta_out != expq[0].theta ||
              longint'(gamma_real_out) != expq[0].gr ||
              longint'(gamma_imag_out) != expq[0].gi ||
              longint'(metric_out) != expq[0].met) begin
            failures++;
            $display("FAIL model_report cyc=%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     cyc, theta_out, gamma_real_out, gamma_imag_out, metric_out,
                     expq[0].theta, expq[0].gr, expq[0].gi, expq[0].met);
          end
          void'(expq.pop_front());
        end
      end else if (expq.size() > 0 && expq[0].due <= cyc) begin
        checks++;
        failures++;
        $display("FAIL model_missing cyc=%0d got no pulse want pulse at %0d",
                 cyc, expq[0].due);
        void'(expq.pop_front());
      end
    end
  end

  task automatic step(input bit v, input int re, im, e, input bit clr);
    int n;
    @(negedge clk);
    n = cyc + 1;
    in_valid = v;
    clear = clr;
    corr_real_in = 20'(re);
    corr_imag_in = 20'(im);
    energy_in = 20'(e);
    if (clr) model_clear(n);
    else if (v && rst_n) model_accept(re, im, e, n);
  endtask

  typedef struct {
    int     fill_re, base_re;
    int     p1_lo, p1_hi, p2_lo, p2_hi;
    int     v_re, v_im, v_en;
    bit     tog;
    int     theta;
    longint gr, gi, met;
  } row_t;
  row_t rows[7];

  task automatic fill16(input int re);
    for (int i = 0; i < CP; i++) step(1, re, 0, 0, 0);
  endtask

  task automatic period(input int r);
    bit inp;
    for (int k = 0; k < SYM; k++) begin
      if (rows[r].tog) step(0, int'($urandom_range(0, 1000)), 7, 3, 0);
      inp = (k >= rows[r].p1_lo && k <= rows[r].p1_hi) ||
            (k >= rows[r].p2_lo && k <= rows[r].p2_hi);
      if (inp) step(1, rows[r].v_re, rows[r].v_im, rows[r].v_en, 0);
      else     step(1, rows[r].base_re, 0, 0, 0);
    end
  endtask

  task automatic await_report(input int r);
    bit seen;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      in_valid = 0;
      clear = 0;
      if (out_valid) begin
        seen = 1;
        checks++;
        if (theta_out != rows[r].theta ||
            longint'(gamma_real_out) != rows[r].gr ||
            longint'(gamma_imag_out) != rows[r].gi ||
            longint'(metric_out) != rows[r].met) begin
          failures++;
          $display("FAIL row%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                   r, theta_out, gamma_real_out, gamma_imag_out, metric_out,
                   rows[r].theta, rows[r].gr, rows[r].gi, rows[r].met);
        end
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL row%0d_timeout got no out_valid want one pulse", r);
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (out_valid !== 1'b0 || theta_out !== '0 || gamma_real_out !== '0 ||
        gamma_imag_out !== '0 || metric_out !== '0) begin
      failures++;
      $display("FAIL %s got %0b/%0d/%0d/%0d/%0d want all zero", nm,
               out_valid, theta_out, gamma_real_out, gamma_imag_out, metric_out);
    end
  endtask

  function automatic int rnd();
    logic signed [19:0] t;
    t = 20'($urandom);
    if ($urandom_range(0, 31) == 0) t = 20'sh80000;
    return int'(t);
  endfunction

  initial begin
    int pc;
    rows[0] = '{1, 1, -1, -1, -1, -1, 0, 0, 0, 0, 0, 16, 0, 16};
    rows[1] = '{0, 0, 50, 65, -1, -1, 100, 0, 0, 0, 65, 1600, 0, 1600};
    rows[2] = '{0, 0, 50, 65, 185, 200, 100, 0, 0, 0, 65, 1600, 0, 1600};
    rows[3] = '{0, 0, 50, 65, -1, -1, 100, 0, 0, 1, 65, 1600, 0, 1600};
    rows[4] = '{0, 0, 10, 25, -1, -1, 0, -200, 0, 0, 25, 0, -3200, 3200};
    rows[5] = '{0, 0, 100, 115, -1, -1, 100, 40, 50, 0, 115, 1600, 640, 1040};
    rows[6] = '{0, 0, 20, 35, -1, -1, -524288, 0, 0, 0, 35, -8388608, 0, 8388607};

    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1;

    for (int r = 0; r < 7; r++) begin
      step(0, 0, 0, 0, 1);
      fill16(rows[r].fill_re);
      period(r);
      await_report(r);
    end

    // clear with a sample at index 120 aborts the period and forces refill
    step(0, 0, 0, 0, 1);
    fill16(0);
    for (int k = 0; k < 120; k++) step(1, 0, 0, 0, 0);
    pc = pulse_cnt;
    step(1, 500, 0, 0, 1);
    for (int k = 0; k < 200; k++) step(1, 0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0);
    checks++;
    if (pulse_cnt != pc) begin
      failures++;
      $display("FAIL clear_abort got %0d pulses want 0", pulse_cnt - pc);
    end
    step(0, 0, 0, 0, 1);
    fill16(0);
    period(1);
    await_report(1);

    // random traffic with bubbles, rare clears and one mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(negedge clk);
        #2 rst_n = 0;
        model_reset();
        in_valid = 0;
        clear = 0;
        @(negedge clk);
        check_zero("mid_reset");
        rst_n = 1;
      end
      step($urandom_range(0, 3) != 0, rnd(), rnd(), rnd(),
           $urandom_range(0, 999) == 0);
    end
    repeat (10) step(0, 0, 0, 0, 0);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL tail_pending got %0d outstanding want 0", expq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
